// File: rtl/cpu_pkg.sv
// Shared core parameters and the reorder-buffer entry type.
package cpu_pkg;

  localparam int unsigned NUM_REG = 32;
  localparam int unsigned NUM_TAG = 64;
  localparam int unsigned NUM_ROB = 16;
  localparam int unsigned TAG_W   = $clog2(NUM_TAG);
  localparam int unsigned IDX_W   = $clog2(NUM_ROB);
  localparam int unsigned RD_W    = $clog2(NUM_REG);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [RD_W-1:0]  rd;
    logic [TAG_W-1:0] tag_old;
    logic [TAG_W-1:0] tag_new;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records renamed instructions, marks completion by index,
// retires the oldest completed entry per cycle and hands its old tag back to rename.
module reorder_buffer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  input  logic [RD_W-1:0]  disp_rd,
  input  logic [TAG_W-1:0] disp_tag_old,
  input  logic [TAG_W-1:0] disp_tag_new,
  output logic [IDX_W-1:0] disp_idx,
  output logic             rob_full,
  input  logic             cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_idx,
  output logic             commit_valid,
  output logic [RD_W-1:0]  commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic             commit_free,
  output logic [TAG_W-1:0] tag_free
);

  localparam logic [IDX_W:0] CountFull = (IDX_W + 1)'(NUM_ROB);

  rob_entry_t       entries_q [NUM_ROB];
  rob_entry_t       entries_d [NUM_ROB];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             disp_fire;
  rob_entry_t       head_entry;

  assign head_entry   = entries_q[head_q];
  assign rob_full     = (count_q == CountFull);
  assign disp_idx     = tail_q;
  assign disp_fire    = disp_valid && !rob_full;
  assign commit_valid = head_entry.valid && head_entry.done;
  assign commit_free  = commit_valid && (head_entry.rd != '0);
  assign commit_rd    = commit_valid ? head_entry.rd : '0;
  assign commit_tag   = commit_valid ? head_entry.tag_new : '0;
  assign tag_free     = commit_free ? head_entry.tag_old : '0;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (commit_valid) begin
      entries_d[head_q] = '0;
      head_d            = head_q + IDX_W'(1);
    end

    // Skipping already-done entries keeps a completion aimed at the retiring head
    // from resurrecting its cleared slot.
    if (cmpl_valid && entries_q[cmpl_idx].valid && !entries_q[cmpl_idx].done) begin
      entries_d[cmpl_idx].done = 1'b1;
    end

    if (disp_fire) begin
      entries_d[tail_q] = '{valid:   1'b1,
                            done:    1'b0,
                            rd:      disp_rd,
                            tag_old: disp_tag_old,
                            tag_new: disp_tag_new};
      tail_d            = tail_q + IDX_W'(1);
    end

    if (disp_fire && !commit_valid) begin
      count_d = count_q + (IDX_W + 1)'(1);
    end else if (!disp_fire && commit_valid) begin
      count_d = count_q - (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROB; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      assert (!(disp_fire && cmpl_valid && (cmpl_idx == tail_q)))
        else $error("completion targets the entry being dispatched");
      for (int i = 0; i < NUM_ROB; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
